// File: rtl/mux_rr_n_if.sv
// Handshake/data bundle for mux_rr_n: per-channel valid/ready inputs, select/mode controls, registered output side.
// master drives inputs and consumes the output; slave is the mux itself.
interface mux_rr_n_if #(
  parameter int WIDTH    = 6,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [SEL_W-1:0]          sel;
  logic                      mode;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output in_data, in_valid, sel, mode, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  modport slave (
    input  in_data, in_valid, sel, mode, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/mux_rr_n.sv
// N-channel registered mux, fixed select or round-robin (MUX_RR_N_RR_EN); 1-cycle latency, 1 word/cycle.
// Backpressure: a held word with out_ready low blocks every in_ready; accept and drain overlap otherwise.
module mux_rr_n #(
  parameter int WIDTH    = 6,
  parameter int CHANNELS = 4
) (
  input logic       clk,
  input logic       rst_n,
  mux_rr_n_if.slave bus
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic             can_load;
  logic             fix_vld;
  logic [SEL_W-1:0] fix_idx;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_dat;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
`ifdef MUX_RR_N_RR_EN
  logic [SEL_W-1:0] ptr_q, ptr_d;
  int               rr_dist;
  int               rr_best;
`endif

  assign can_load = !out_valid_q || bus.out_ready;

  // Out-of-range selects match no channel, so they never grant.
  always_comb begin
    fix_vld = 1'b0;
    fix_idx = '0;
    for (int j = 0; j < CHANNELS; j++) begin
      if (bus.sel == SEL_W'(j) && bus.in_valid[j]) begin
        fix_vld = 1'b1;
        fix_idx = SEL_W'(j);
      end
    end
  end

`ifdef MUX_RR_N_RR_EN
  // Closest valid channel after ptr (distance 0 = ptr+1) wins.
  always_comb begin
    grant_vld = fix_vld;
    grant_idx = fix_idx;
    rr_dist   = 0;
    rr_best   = CHANNELS;
    if (bus.mode) begin
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int j = 0; j < CHANNELS; j++) begin
        rr_dist = j - int'(ptr_q) - 1;
        if (rr_dist < 0) rr_dist = rr_dist + CHANNELS;
        if (bus.in_valid[j] && rr_dist < rr_best) begin
          rr_best   = rr_dist;
          grant_vld = 1'b1;
          grant_idx = SEL_W'(j);
        end
      end
    end
  end
`else
  assign grant_vld = fix_vld;
  assign grant_idx = fix_idx;
`endif

  always_comb begin
    grant_dat    = '0;
    bus.in_ready = '0;
    for (int j = 0; j < CHANNELS; j++) begin
      if (grant_idx == SEL_W'(j)) begin
        grant_dat = bus.in_data[j*WIDTH +: WIDTH];
        bus.in_ready[j] = rst_n && can_load && grant_vld;
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
`ifdef MUX_RR_N_RR_EN
    ptr_d       = ptr_q;
`endif
    if (can_load) begin
      if (grant_vld) begin
        out_data_d  = grant_dat;
        out_chan_d  = grant_idx;
        out_valid_d = 1'b1;
`ifdef MUX_RR_N_RR_EN
        ptr_d       = grant_idx;
`endif
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef MUX_RR_N_RR_EN
      ptr_q       <= SEL_W'(CHANNELS - 1);
`endif
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
`ifdef MUX_RR_N_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_mux_rr_n.sv
// Scoreboard bench for mux_rr_n: stimulus pushes expected {chan,data}; a negedge monitor pops on each output handshake.
module tb_mux_rr_n;
  localparam int W = 6;

  typedef struct packed {
    logic [1:0] chan;
    logic [5:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_rr_n_if #(.WIDTH(W), .CHANNELS(4)) if4 ();
  mux_rr_n_if #(.WIDTH(W), .CHANNELS(3)) if3 ();

  mux_rr_n #(.WIDTH(W), .CHANNELS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  mux_rr_n #(.WIDTH(W), .CHANNELS(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  exp_t mon_e;

`ifdef MUX_RR_N_RR_EN
  int rr1[5] = '{0, 1, 2, 3, 0};
  int rr2[4] = '{1, 3, 1, 3};
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic push_exp(input int c, input int d);
    sb_q.push_back({2'(c), 6'(d)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (if4.out_valid === 1'b1 && if4.out_ready === 1'b1) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got chan %0d data %0h, expected no word", if4.out_chan, if4.out_data);
      end else begin
        mon_e = sb_q.pop_front();
        if ({if4.out_chan, if4.out_data} !== mon_e) begin
          n_err++;
          $display("FAIL sb_word: got chan %0d data %0h, expected chan %0d data %0h",
                   if4.out_chan, if4.out_data, mon_e.chan, mon_e.data);
        end
      end
    end
  end

  initial begin
    // Reset with every channel valid.
    if4.in_data = '0; if4.in_valid = 4'hF; if4.sel = 2'd0; if4.mode = 1'b0; if4.out_ready = 1'b1;
    if3.in_data = '0; if3.in_valid = 3'h7; if3.sel = 2'd0; if3.mode = 1'b0; if3.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_out_valid", 32'(if4.out_valid), 32'd0);
      chk("rst_out_data", 32'(if4.out_data), 32'd0);
      chk("rst_out_chan", 32'(if4.out_chan), 32'd0);
      chk("rst_in_ready", 32'(if4.in_ready), 32'd0);
      chk("rst_in_ready3", 32'(if3.in_ready), 32'd0);
    end
    step();
    rst_n = 1'b1;
    if3.in_valid = 3'h0;

    // Fixed-mode sweep: selected channel carries v, the rest carry 0x3F-v.
    for (int s = 0; s < 4; s++) begin
      for (int v = 0; v < 64; v++) begin
        if4.sel = 2'(s);
        for (int i = 0; i < 4; i++)
          if4.in_data[i*W +: W] = (i == s) ? 6'(v) : 6'(63 - v);
        push_exp(s, v);
        step();
      end
    end
    if4.in_valid = 4'h0;
    step();
    @(negedge clk);
    chk("idle_out_valid", 32'(if4.out_valid), 32'd0);
    step();

    if4.in_data = {6'd4, 6'd3, 6'd2, 6'd1};
`ifdef MUX_RR_N_RR_EN
    if4.mode = 1'b1;
    if4.in_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      push_exp(rr1[k], rr1[k] + 1);
      step();
    end
    if4.in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      push_exp(rr2[k], rr2[k] + 1);
      step();
    end
    if4.in_valid = 4'h0;
    step();
`endif

    // Backpressure: hold ch0's word for 4 cycles, then accept ch1 while draining.
    if4.mode = 1'b1; if4.sel = 2'd0; if4.in_valid = 4'hF; if4.out_ready = 1'b1;
    push_exp(0, 1);
    step();
    if4.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(if4.out_valid), 32'd1);
      chk("bp_out_data", 32'(if4.out_data), 32'd1);
      chk("bp_out_chan", 32'(if4.out_chan), 32'd0);
      chk("bp_in_ready", 32'(if4.in_ready), 32'd0);
      step();
    end
    if4.out_ready = 1'b1; if4.sel = 2'd1;
    push_exp(1, 2);
    @(negedge clk);
    chk("bp_release_in_ready", 32'(if4.in_ready), 32'b0010);
    step();

    // Reset while a word is held discards it; the next grants restart from channel 0.
    if4.in_valid = 4'b0100; if4.sel = 2'd2;
    step();
    if4.out_ready = 1'b0; rst_n = 1'b0; if4.in_valid = 4'hF;
    @(negedge clk);
    chk("mid_rst_held_valid", 32'(if4.out_valid), 32'd1);
    chk("mid_rst_held_chan", 32'(if4.out_chan), 32'd2);
    chk("mid_rst_in_ready", 32'(if4.in_ready), 32'd0);
    step();
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(if4.out_valid), 32'd0);
    chk("mid_rst_out_chan", 32'(if4.out_chan), 32'd0);
    step();
    rst_n = 1'b1; if4.out_ready = 1'b1; if4.sel = 2'd0;
    push_exp(0, 1);
    step();
    if4.sel = 2'd1;
    push_exp(1, 2);
    step();
    if4.in_valid = 4'h0;
    step();

`ifndef MUX_RR_N_RR_EN
    // Without round-robin, mode is ignored and sel alone grants.
    if4.mode = 1'b1; if4.sel = 2'd2; if4.in_valid = 4'hF;
    for (int k = 0; k < 4; k++) begin
      push_exp(2, 3);
      @(negedge clk);
      chk("noRR_in_ready", 32'(if4.in_ready), 32'b0100);
      step();
    end
    if4.in_valid = 4'h0;
    step();
`endif

    // Three channels: sel = 3 is out of range and must drop out_valid.
    if3.in_data = {6'h23, 6'h12, 6'h05}; if3.sel = 2'd0; if3.in_valid = 3'h7; if3.out_ready = 1'b1;
    step();
    if3.sel = 2'd3;
    @(negedge clk);
    chk("c3_out_valid", 32'(if3.out_valid), 32'd1);
    chk("c3_out_chan", 32'(if3.out_chan), 32'd0);
    chk("c3_out_data", 32'(if3.out_data), 32'h05);
    chk("c3_sel3_in_ready", 32'(if3.in_ready), 32'd0);
    step();
    @(negedge clk);
    chk("c3_sel3_out_valid", 32'(if3.out_valid), 32'd0);
    chk("c3_stale_data", 32'(if3.out_data), 32'h05);
    step();
    step();

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
